fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer of the async FIFO, living in the read clock domain.
//  Issues r_en to the FIFO whenever words are available and downstream
//  space is guaranteed, and captures data_out after the FIFO read latency.
//  Presents the words as a valid/ready stream through an internal output
//  buffer, plus a drain-controlled enable, a word counter and a sticky error flag.
// PARAMETERS
//  DATA_WIDTH  8   FIFO word width; matches the FIFO DATA_WIDTH
//  RD_LAT      1   cycles from r_en sampled high to data_out valid (1..3)
//  OBUF_DEPTH  4   output buffer entries; power of 2, >= RD_LAT+1
//  CNT_WIDTH   16  width of the drained-word counter
// PORTS
//  rclk        in   1            read-domain clock
//  rrst        in   1            synchronous active-high reset
//  enable      in   1            1 = fetch from FIFO; 0 = stop fetching, drain
//  fifo_empty  in   1            FIFO empty flag (rclk domain)
//  fifo_rerr   in   1            FIFO read_error flag
//  fifo_data   in   DATA_WIDTH   FIFO data_out
//  fifo_r_en   out  1            FIFO read enable
//  m_valid     out  1            stream word valid
//  m_data      out  DATA_WIDTH   stream word
//  m_ready     in   1            downstream accepts word when m_valid&m_ready
//  busy        out  1            state != IDLE
//  err_sticky  out  1            set on any FIFO read error, cleared by rrst only
//  word_cnt    out  CNT_WIDTH    words delivered downstream; wraps at 2^CNT_WIDTH
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Clock and
//   reset ports are rclk and rrst.
//  Reset: on rising rclk with rrst=1: all outputs 0, state=IDLE, buffer
//   and in-flight tracking cleared. Words in flight or buffered are dropped;
//   the FIFO must be reset in the same window.
//  Issue rule, combinational:
//   fifo_r_en = (state==ACTIVE) & ~fifo_empty & (occ + infl < OBUF_DEPTH).
//   occ = buffered words. infl = reads issued whose data has not yet returned.
//  Return: an RD_LAT-deep shift register of issue bits. When a bit exits,
//   fifo_data is written into the buffer in that cycle. Writes never overflow
//   because of the issue rule.
//  Stream: m_valid = (occ != 0). m_data = buffer head, registered and stable
//   while m_valid & ~m_ready. Pop on m_valid & m_ready. A write and a pop in
//   the same cycle leave occ unchanged. word_cnt increments on each pop.
//  Throughput: with m_ready held at 1 and the FIFO non-empty, the block
//   sustains 1 word/cycle. First m_valid appears RD_LAT+1 cycles after the
//   first fifo_r_en.
//  FSM:
//   IDLE -> ACTIVE      when enable=1
//   ACTIVE -> STOPPING  when enable=0; no new reads are issued
//   STOPPING -> IDLE    when infl==0 & occ==0
//   STOPPING -> ACTIVE  when enable=1 again; in-flight data is kept
//  Errors: fifo_rerr=1 in any cycle sets err_sticky. Data is not blocked.
//   If fifo_empty rises in the same cycle the block issues, no r_en is issued,
//   because the rule is combinational on the current fifo_empty.
//  Boundaries: occ == OBUF_DEPTH-infl stalls issue. Buffer pointers wrap
//   modulo OBUF_DEPTH. word_cnt wraps from all-ones to 0. rrst asserted
//   mid-stream drops m_valid on the next edge.
// TESTING
//  T1 reset: rrst=1 for 2 cycles -> all outputs 0, busy=0.
//  T2 stream: preload FIFO 0x01..0x08, enable=1, m_ready=1 ->
//     m_data 0x01..0x08 in order on 8 consecutive cycles, word_cnt=8.
//  T3 backpressure: m_ready=0 with 8 words available ->
//     exactly OBUF_DEPTH(4) r_en pulses, m_data holds 0x01.
//     Release m_ready -> remaining words delivered, none lost.
//  T4 drain: enable=0 while 2 words are in flight ->
//     no new r_en, both words delivered, then busy=0.
//  T5 error/empty: r_en while FIFO is empty via forced fifo_rerr=1 ->
//     err_sticky=1 until rrst; fifo_empty=1 -> fifo_r_en=0.
//  T6 wrap: start with word_cnt at 0xFFFF, deliver 2 words -> word_cnt=0x0001.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready word stream leaving the FIFO read-side consumer.
// The master drives valid/data. The slave drives ready.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of an async FIFO, running in the read clock domain.
// Reads are issued only when the output buffer can absorb every word already
// in flight plus the new one. This lets returning words be written blindly
// after RD_LAT cycles, and a full-rate stream survives downstream stalls.
// OBUF_DEPTH must be a power of two and at least RD_LAT+1. RD_LAT is 1..3.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LAT     = 1,
   parameter int OBUF_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_rerr,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   fifo_rd_stream_if.master      m,
   output logic                  busy,
   output logic                  err_sticky,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);
   localparam int OCC_W = $clog2(OBUF_DEPTH + 1);
   localparam logic [OCC_W:0] DEPTH_W = (OCC_W + 1)'(OBUF_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_STOPPING
   } state_e;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [OCC_W-1:0]      infl_q, infl_d;
   logic [RD_LAT-1:0]     issue_sr_q, issue_sr_d;
   logic                  err_sticky_q, err_sticky_d;
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic [DATA_WIDTH-1:0] buf_q [OBUF_DEPTH];

   logic                  issue;
   logic                  ret;
   logic                  pop;
   logic                  m_valid;
   logic [OCC_W:0]        pending;

   // Issue decision: words already buffered plus words still returning must leave room for one more.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      pending = {1'b0, occ_q} + {1'b0, infl_q};
      issue   = 1'b0;
      if ((state_q == ST_ACTIVE) && !fifo_empty && (pending < DEPTH_W)) begin
         issue = 1'b1;
      end
   end

   // A read issued RD_LAT cycles ago returns now. A buffered head word is taken when downstream is ready.
   always_comb begin
      ret     = issue_sr_q[RD_LAT-1];
      m_valid = (occ_q != '0);
      pop     = m_valid && m.m_ready;
   end

   // Next-state for the buffer pointers, occupancy, in-flight count, counter and error flag.
   always_comb begin
      issue_sr_d    = '0;
      issue_sr_d[0] = issue;
      for (int i = 1; i < RD_LAT; i++) begin
         issue_sr_d[i] = issue_sr_q[i-1];
      end

      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      infl_d       = infl_q;
      word_cnt_d   = word_cnt_q;
      err_sticky_d = err_sticky_q | fifo_rerr;

      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (ret) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      end

      case ({ret, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase

      case ({issue, ret})
         2'b10:   infl_d = infl_q + OCC_W'(1);
         2'b01:   infl_d = infl_q - OCC_W'(1);
         default: infl_d = infl_q;
      endcase
   end

   // FSM next state. Stopping waits for every outstanding word to leave before going idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!enable) state_d = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (enable) begin
               state_d = ST_ACTIVE;
            end else if ((infl_q == '0) && (occ_q == '0)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state register. Synchronous reset drops everything in flight or buffered.
   always_ff @(posedge rclk) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values regardless of block order.
      if (rrst) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         infl_q       <= '0;
         issue_sr_q   <= '0;
         err_sticky_q <= 1'b0;
         word_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         infl_q       <= infl_d;
         issue_sr_q   <= issue_sr_d;
         err_sticky_q <= err_sticky_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   // Output buffer storage. A returning word is written at the tail.
   always_ff @(posedge rclk) begin
      // NOTE: the storage array has no reset. Validity comes only from occ_q, and m_data is gated to zero while the buffer is empty.
      if (ret) begin
         buf_q[wr_ptr_q] <= fifo_data;
      end
   end

   assign fifo_r_en  = issue;
   assign m.m_valid  = m_valid;
   assign m.m_data   = m_valid ? buf_q[rd_ptr_q] : '0;
   assign busy       = (state_q != ST_IDLE);
   assign err_sticky = err_sticky_q;
   assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream.
// A behavioural FIFO with one cycle of read latency feeds the DUT.
// Every word loaded into the FIFO is also queued as an expected stream word.
// A monitor pops that queue on each handshake and compares data and the counter.
// The counter is narrowed to 8 bits so its wrap is reachable in a short run.
module tb_fifo_rd_stream;
   localparam int DW         = 8;
   localparam int RD_LAT     = 1;
   localparam int OBUF_DEPTH = 4;
   localparam int CNT_W      = 8;

   logic             rclk = 1'b0;
   logic             rrst;
   logic             enable;
   logic             fifo_empty;
   logic             fifo_rerr;
   logic [DW-1:0]    fifo_data = '0;
   logic             fifo_r_en;
   logic             busy;
   logic             err_sticky;
   logic [CNT_W-1:0] word_cnt;

   always #5 rclk = ~rclk;

   fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();

   fifo_rd_stream #(
      .DATA_WIDTH (DW),
      .RD_LAT     (RD_LAT),
      .OBUF_DEPTH (OBUF_DEPTH),
      .CNT_WIDTH  (CNT_W)
   ) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_rerr  (fifo_rerr),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .m          (s_if),
      .busy       (busy),
      .err_sticky (err_sticky),
      .word_cnt   (word_cnt)
   );

   // Behavioural FIFO: read data appears one cycle after r_en is sampled.
   logic [DW-1:0] fifo_mem [1024];
   int            wr_idx = 0;
   int            rd_idx = 0;
   logic          force_empty = 1'b0;
   logic          rerr_drive  = 1'b0;

   assign fifo_empty = force_empty | (rd_idx == wr_idx);
   assign fifo_rerr  = rerr_drive;

   // FIFO read port model. It is reset in the same window as the DUT.
   always @(posedge rclk) begin
      if (rrst) begin
         rd_idx    <= wr_idx;
         fifo_data <= '0;
      end else if (fifo_r_en && (rd_idx != wr_idx)) begin
         fifo_data <= fifo_mem[rd_idx];
         rd_idx    <= rd_idx + 1;
      end
   end

   // Scoreboard and bookkeeping.
   logic [DW-1:0]    sb_q [$];
   logic [CNT_W-1:0] exp_cnt = '0;
   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int ren_cnt  = 0;
   int pop_cnt  = 0;
   int ren_first   = -1;
   int valid_first = -1;
   int pop_first   = -1;
   int pop_last    = -1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge rclk);
   endtask

   task automatic preload(input logic [DW-1:0] v);
      fifo_mem[wr_idx] = v;
      wr_idx++;
      sb_q.push_back(v);
   endtask

   task automatic do_reset(input int n);
      rrst = 1'b1;
      sb_q.delete();
      exp_cnt = '0;
      tick(n);
      rrst = 1'b0;
   endtask

   task automatic wait_drain(input string nm, input int max_cyc);
      for (int i = 0; (i < max_cyc) && (sb_q.size() != 0); i++) tick();
      #2 check(nm, sb_q.size(), 0);
   endtask

   task automatic wait_idle(input string nm, input int max_cyc);
      for (int i = 0; (i < max_cyc) && busy; i++) tick();
      #2 check(nm, 32'(busy), 0);
   endtask

   // Monitor: samples mid-cycle and checks every handshake against the scoreboard.
   initial begin : monitor
      logic [DW-1:0] exp_w;
      forever begin
         @(negedge rclk);
         #1;
         cyc++;
         if (!rrst) begin
            if (fifo_r_en) begin
               ren_cnt++;
               if (ren_first < 0) ren_first = cyc;
            end
            if (s_if.m_valid && (valid_first < 0)) valid_first = cyc;
            if (s_if.m_valid && s_if.m_ready) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL unexpected_word: got 0x%0h with no word expected", s_if.m_data);
               end else begin
                  exp_w = sb_q.pop_front();
                  check("m_data", 32'(s_if.m_data), 32'(exp_w));
                  check("word_cnt_at_pop", 32'(word_cnt), 32'(exp_cnt));
               end
               exp_cnt++;
               pop_cnt++;
               if (pop_first < 0) pop_first = cyc;
               pop_last = cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rrst        = 1'b1;
      enable      = 1'b0;
      s_if.m_ready = 1'b0;

      // T1 reset: two reset cycles, then every output must be zero.
      do_reset(2);
      #2;
      check("t1_m_valid",    32'(s_if.m_valid), 0);
      check("t1_m_data",     32'(s_if.m_data),  0);
      check("t1_fifo_r_en",  32'(fifo_r_en),    0);
      check("t1_busy",       32'(busy),         0);
      check("t1_err_sticky", 32'(err_sticky),   0);
      check("t1_word_cnt",   32'(word_cnt),     0);

      // T2 stream: 8 words at full rate, first valid RD_LAT+1 cycles after the first read.
      tick();
      for (int i = 1; i <= 8; i++) preload(DW'(i));
      ren_first    = -1;
      valid_first  = -1;
      pop_first    = -1;
      s_if.m_ready = 1'b1;
      enable       = 1'b1;
      wait_drain("t2_drained", 40);
      check("t2_latency", valid_first - ren_first, RD_LAT + 1);
      check("t2_burst_span", pop_last - pop_first, 7);
      check("t2_word_cnt", 32'(word_cnt), 8);
      tick();
      enable = 1'b0;
      wait_idle("t2_idle", 10);

      // T3 backpressure: the buffer fills to OBUF_DEPTH reads, and the head word holds.
      tick();
      ren_cnt      = 0;
      s_if.m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) preload(DW'(i));
      enable = 1'b1;
      tick(10);
      #2;
      check("t3_ren_pulses", ren_cnt, OBUF_DEPTH);
      check("t3_m_valid", 32'(s_if.m_valid), 1);
      check("t3_m_data_head", 32'(s_if.m_data), 32'h01);
      tick(3);
      #2;
      check("t3_m_data_held", 32'(s_if.m_data), 32'h01);
      check("t3_ren_still", ren_cnt, OBUF_DEPTH);
      tick();
      s_if.m_ready = 1'b1;
      wait_drain("t3_drained", 40);
      check("t3_ren_total", ren_cnt, 8);
      tick();
      enable = 1'b0;
      wait_idle("t3_idle", 10);

      // T4 drain: enable drops with two reads outstanding. Both are delivered, then the block goes idle.
      tick();
      ren_cnt = 0;
      pop_cnt = 0;
      for (int i = 0; i < 8; i++) preload(DW'(8'h11 + i));
      s_if.m_ready = 1'b1;
      enable       = 1'b1;
      tick(2);
      enable = 1'b0;
      tick(8);
      #2;
      check("t4_ren_after_stop", ren_cnt, 2);
      check("t4_words_delivered", pop_cnt, 2);
      check("t4_busy", 32'(busy), 0);
      // Resume with downstream stalled, then reset mid-stream. m_valid must drop on that edge.
      tick();
      s_if.m_ready = 1'b0;
      enable       = 1'b1;
      tick(6);
      #2;
      check("t4_resume_valid", 32'(s_if.m_valid), 1);
      check("t4_resume_head", 32'(s_if.m_data), 32'h13);
      tick();
      enable = 1'b0;
      do_reset(1);
      #2;
      check("t4_rst_m_valid", 32'(s_if.m_valid), 0);
      check("t4_rst_word_cnt", 32'(word_cnt), 0);

      // T5 error and empty: read error sets the sticky flag. An empty FIFO blocks every read.
      tick();
      ren_cnt      = 0;
      s_if.m_ready = 1'b1;
      enable       = 1'b1;
      rerr_drive   = 1'b1;
      tick();
      rerr_drive = 1'b0;
      tick(4);
      #2;
      check("t5_err_sticky", 32'(err_sticky), 1);
      check("t5_ren_empty", 32'(fifo_r_en), 0);
      check("t5_busy_active", 32'(busy), 1);
      tick();
      force_empty = 1'b1;
      preload(8'h21);
      preload(8'h22);
      tick(4);
      #2;
      check("t5_ren_forced_empty", ren_cnt, 0);
      check("t5_err_still", 32'(err_sticky), 1);
      tick();
      force_empty = 1'b0;
      wait_drain("t5_drained", 20);
      check("t5_ren_total", ren_cnt, 2);
      tick();
      enable = 1'b0;
      wait_idle("t5_idle", 10);
      tick();
      do_reset(1);
      #2;
      check("t5_err_cleared", 32'(err_sticky), 0);

      // T6 wrap: 255 words take the counter to all-ones. Two more words wrap it to 1.
      tick();
      s_if.m_ready = 1'b1;
      for (int i = 0; i < 255; i++) preload(DW'(i));
      enable = 1'b1;
      wait_drain("t6_drained_255", 400);
      check("t6_word_cnt_ones", 32'(word_cnt), 32'hFF);
      tick();
      preload(8'hA5);
      preload(8'h5A);
      wait_drain("t6_drained_257", 20);
      check("t6_word_cnt_wrap", 32'(word_cnt), 32'h01);
      tick();
      enable = 1'b0;
      wait_idle("t6_idle", 10);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
